// File: rtl/randomizer_pkg.sv
// Shared randomizer definitions: the word-parallel LFSR next-state function used
// by both generator and checker, its tap constants, and the checker sync states.
package randomizer_pkg;

  localparam int RNDM_MAX_W = 64;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // Fibonacci feedback masks: bit t-1 is set for every polynomial term x^t.
  localparam logic [RNDM_MAX_W-1:0] TAPS_W8  = 64'h0000_0000_0000_00B8;
  localparam logic [RNDM_MAX_W-1:0] TAPS_W16 = 64'h0000_0000_0000_B400;
  localparam logic [RNDM_MAX_W-1:0] TAPS_W24 = 64'h0000_0000_00E1_0000;
  localparam logic [RNDM_MAX_W-1:0] TAPS_W32 = 64'h0000_0000_8020_0003;

  function automatic logic [RNDM_MAX_W-1:0] rndm_taps(input int width);
    case (width)
      8:       return TAPS_W8;
      16:      return TAPS_W16;
      24:      return TAPS_W24;
      32:      return TAPS_W32;
      default: return 64'h3 << (width - 2);
    endcase
  endfunction

  // One output word advances the register by 'width' serial shifts, so every
  // bit of the next word is fresh sequence.
  function automatic logic [RNDM_MAX_W-1:0] rndm_next(input logic [RNDM_MAX_W-1:0] state,
                                                      input int width);
    logic [RNDM_MAX_W-1:0] s;
    logic [RNDM_MAX_W-1:0] taps;
    logic [RNDM_MAX_W-1:0] wmask;
    taps  = rndm_taps(width);
    wmask = (width >= RNDM_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    s     = state & wmask;
    for (int i = 0; i < RNDM_MAX_W; i++) begin
      if (i < width) begin
        s = ((s << 1) | {63'd0, ^(s & taps)}) & wmask;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/rndm_checker.sv
// Multi-channel randomizer checker: self-synchronises a per-channel LFSR copy to
// the received words, declares lock, then flags and counts word errors.
module rndm_checker
  import randomizer_pkg::*;
#(
  parameter int NR_CHANNELS   = 1,
  parameter int OUTPUT_WIDTH  = 16,
  parameter int LOCK_COUNT    = 4,
  parameter int LOSS_COUNT    = 4,
  parameter int ERR_CNT_WIDTH = 16,
  localparam int CH_W = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_W-1:0]          chk_ch,
  input  logic [OUTPUT_WIDTH-1:0]  chk_data,
  input  logic                     chk_valid,
  output logic                     chk_out_valid,
  output logic [CH_W-1:0]          chk_out_ch,
  output logic                     chk_match,
  output logic                     chk_err,
  output logic [NR_CHANNELS-1:0]   chk_locked,
  input  logic [CH_W-1:0]          cnt_rd_ch,
  input  logic                     cnt_clr,
  output logic [ERR_CNT_WIDTH-1:0] cnt_rd_val
);

  // Contexts are sized to the full index range so any chk_ch value addresses a
  // real entry; entries at or above NR_CHANNELS are never written.
  localparam int CH_DEPTH = 1 << CH_W;
  localparam int RUN_MAX  = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int RUN_W    = (RUN_MAX > 1) ? $clog2(RUN_MAX) : 1;

  logic [OUTPUT_WIDTH-1:0]  r_lfsr    [CH_DEPTH];
  chk_state_e               r_state   [CH_DEPTH];
  logic [RUN_W-1:0]         r_run     [CH_DEPTH];
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt [CH_DEPTH];

  logic                     r_out_valid;
  logic [CH_W-1:0]          r_out_ch;
  logic                     r_match;
  logic                     r_err;
  logic [ERR_CNT_WIDTH-1:0] r_cnt_rd_val;

  logic                     w_hit;
  logic [OUTPUT_WIDTH-1:0]  w_lfsr_cur;
  chk_state_e               w_state_cur;
  logic [RUN_W-1:0]         w_run_cur;
  logic [OUTPUT_WIDTH-1:0]  w_expected;
  logic                     w_match;
  logic                     w_err;
  logic [OUTPUT_WIDTH-1:0]  w_lfsr_nxt;
  chk_state_e               w_state_nxt;
  logic [RUN_W-1:0]         w_run_nxt;
  logic [ERR_CNT_WIDTH-1:0] w_cnt_next [CH_DEPTH];

  assign w_hit       = chk_valid && ({1'b0, chk_ch} < (CH_W + 1)'(NR_CHANNELS));
  assign w_lfsr_cur  = r_lfsr[chk_ch];
  assign w_state_cur = r_state[chk_ch];
  assign w_run_cur   = r_run[chk_ch];
  assign w_expected  = OUTPUT_WIDTH'(rndm_next(RNDM_MAX_W'(w_lfsr_cur), OUTPUT_WIDTH));
  assign w_match     = (chk_data == w_expected) && (chk_data != '0);

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    w_lfsr_nxt  = chk_data;
    w_state_nxt = w_state_cur;
    w_run_nxt   = w_run_cur;
    w_err       = 1'b0;
    if (w_state_cur == SEARCH) begin
      if (!w_match) begin
        w_run_nxt = '0;
      end else if (w_run_cur == RUN_W'(LOCK_COUNT - 1)) begin
        w_state_nxt = LOCKED;
        w_run_nxt   = '0;
      end else begin
        w_run_nxt = w_run_cur + RUN_W'(1);
      end
    end else begin
      // Flywheel: while locked the prediction runs on, ignoring corrupted words.
      w_lfsr_nxt = w_expected;
      if (w_match) begin
        w_run_nxt = '0;
      end else begin
        w_err = 1'b1;
        if (w_run_cur == RUN_W'(LOSS_COUNT - 1)) begin
          w_state_nxt = SEARCH;
          w_run_nxt   = '0;
          w_lfsr_nxt  = chk_data;
        end else begin
          w_run_nxt = w_run_cur + RUN_W'(1);
        end
      end
    end
  end

  // A clear that coincides with an increment on the same channel keeps that error.
  always_comb begin
    for (int c = 0; c < CH_DEPTH; c++) begin
      w_cnt_next[c] = r_err_cnt[c];
      if (cnt_clr && (cnt_rd_ch == CH_W'(c))) begin
        w_cnt_next[c] = (w_hit && w_err && (chk_ch == CH_W'(c))) ? ERR_CNT_WIDTH'(1) : '0;
      end else if (w_hit && w_err && (chk_ch == CH_W'(c)) && (r_err_cnt[c] != '1)) begin
        w_cnt_next[c] = r_err_cnt[c] + ERR_CNT_WIDTH'(1);
      end
    end
  end

  // NOTE: the context arrays are small register files whose reset contents
  // define SEARCH entry, so they are reset explicitly rather than left as RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH_DEPTH; c++) begin
        r_lfsr[c]    <= '0;
        r_state[c]   <= SEARCH;
        r_run[c]     <= '0;
        r_err_cnt[c] <= '0;
      end
      r_out_valid  <= 1'b0;
      r_out_ch     <= '0;
      r_match      <= 1'b0;
      r_err        <= 1'b0;
      r_cnt_rd_val <= '0;
    end else begin
      if (w_hit) begin
        r_lfsr[chk_ch]  <= w_lfsr_nxt;
        r_state[chk_ch] <= w_state_nxt;
        r_run[chk_ch]   <= w_run_nxt;
      end
      for (int c = 0; c < CH_DEPTH; c++) begin
        r_err_cnt[c] <= w_cnt_next[c];
      end
      r_out_valid  <= w_hit;
      r_out_ch     <= w_hit ? chk_ch : '0;
      r_match      <= w_hit && w_match;
      r_err        <= w_hit && w_err;
      r_cnt_rd_val <= w_cnt_next[cnt_rd_ch];
    end
  end

  always_comb begin
    chk_locked = '0;
    for (int c = 0; c < NR_CHANNELS; c++) begin
      chk_locked[c] = (r_state[c] == LOCKED);
    end
  end

  assign chk_out_valid = r_out_valid;
  assign chk_out_ch    = r_out_ch;
  assign chk_match     = r_match;
  assign chk_err       = r_err;
  assign cnt_rd_val    = r_cnt_rd_val;

endmodule

// File: tb/tb_rndm_checker.sv
// Self-checking bench for rndm_checker: directed vector table, hand-written
// corner sequences, and randomized traffic against a sequence-level model.
module tb_rndm_checker;

  localparam int NR   = 3;
  localparam int W    = 24;
  localparam int LOCK = 4;
  localparam int LOSS = 4;
  localparam int ECW  = 4;
  localparam int CMAX = (1 << ECW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     chk_ch = '0;
  logic [W-1:0]   chk_data = '0;
  logic           chk_valid = 1'b0;
  logic           chk_out_valid;
  logic [1:0]     chk_out_ch;
  logic           chk_match;
  logic           chk_err;
  logic [NR-1:0]  chk_locked;
  logic [1:0]     cnt_rd_ch = '0;
  logic           cnt_clr = 1'b0;
  logic [ECW-1:0] cnt_rd_val;

  int n_checks = 0;
  int n_fail   = 0;

  rndm_checker #(
    .NR_CHANNELS  (NR),
    .OUTPUT_WIDTH (W),
    .LOCK_COUNT   (LOCK),
    .LOSS_COUNT   (LOSS),
    .ERR_CNT_WIDTH(ECW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .chk_ch       (chk_ch),
    .chk_data     (chk_data),
    .chk_valid    (chk_valid),
    .chk_out_valid(chk_out_valid),
    .chk_out_ch   (chk_out_ch),
    .chk_match    (chk_match),
    .chk_err      (chk_err),
    .chk_locked   (chk_locked),
    .cnt_rd_ch    (cnt_rd_ch),
    .cnt_clr      (cnt_clr),
    .cnt_rd_val   (cnt_rd_val)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Sequence view of the x^24+x^23+x^22+x^17+1 generator: word bit i is sequence
  // element n-i, and each new element is the XOR of the elements 24,23,22,17 back.
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] w);
    bit          b [2*W];
    logic [W-1:0] r;
    for (int j = 0; j < W; j++) b[j] = w[W-1-j];
    for (int k = W; k < 2*W; k++) b[k] = b[k-24] ^ b[k-23] ^ b[k-22] ^ b[k-17];
    for (int i = 0; i < W; i++) r[i] = b[2*W-1-i];
    return r;
  endfunction

  logic [W-1:0] gen [NR] = '{24'h040000, 24'h000400, 24'h000004};

  function automatic logic [W-1:0] gen_word(input int ch);
    gen[ch] = ref_next(gen[ch]);
    return gen[ch];
  endfunction

  // Reference model: prediction base, lock flag, streak length, error count.
  logic [W-1:0] m_base   [NR];
  bit           m_locked [NR];
  int           m_run    [NR];
  int           m_cnt    [NR];

  task automatic model_reset();
    for (int c = 0; c < NR; c++) begin
      m_base[c] = '0; m_locked[c] = 0; m_run[c] = 0; m_cnt[c] = 0;
    end
  endtask

  task automatic model_word(input int ch, input logic [W-1:0] d, output bit mt, output bit er);
    logic [W-1:0] pred;
    pred = ref_next(m_base[ch]);
    mt = (d == pred) && (d != 0);
    er = 0;
    if (!m_locked[ch]) begin
      m_base[ch] = d;
      m_run[ch]  = mt ? m_run[ch] + 1 : 0;
      if (m_run[ch] == LOCK) begin m_locked[ch] = 1; m_run[ch] = 0; end
    end else if (mt) begin
      m_base[ch] = pred;
      m_run[ch]  = 0;
    end else begin
      er = 1;
      if (m_cnt[ch] < CMAX) m_cnt[ch]++;
      m_run[ch]++;
      if (m_run[ch] == LOSS) begin
        m_locked[ch] = 0; m_run[ch] = 0; m_base[ch] = d;
      end else begin
        m_base[ch] = pred;
      end
    end
  endtask

  function automatic logic [NR-1:0] model_locked();
    logic [NR-1:0] v;
    for (int c = 0; c < NR; c++) v[c] = m_locked[c];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int ch, input logic [W-1:0] d,
                       input bit clr, input int rd, input bit r);
    rst = r; chk_valid = v; chk_ch = 2'(ch); chk_data = d;
    cnt_clr = clr; cnt_rd_ch = 2'(rd);
    @(posedge clk);
    #1;
    rst = 1'b0; chk_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic send(input bit v, input int ch, input logic [W-1:0] d,
                      input bit clr, input int rd, input bit r);
    bit ev, em, ee;
    int ecnt;
    ev = 0; em = 0; ee = 0; ecnt = 0;
    if (r) begin
      model_reset();
    end else begin
      if (v && ch < NR) begin
        ev = 1;
        model_word(ch, d, em, ee);
      end
      if (clr && rd < NR) m_cnt[rd] = (ee && ch == rd) ? 1 : 0;
      if (rd < NR) ecnt = m_cnt[rd];
    end
    drive(v, ch, d, clr, rd, r);
    check("result", 32'({chk_out_valid, chk_match, chk_err}), 32'({ev, em, ee}));
    if (ev) check("out_ch", 32'(chk_out_ch), 32'(ch));
    check("locked", 32'(chk_locked), 32'(model_locked()));
    check("cnt_rd", 32'(cnt_rd_val), 32'(ecnt));
  endtask

  typedef struct {
    bit           v;
    int           ch;
    logic [W-1:0] xm;
    bit           adv;
    bit           ev;
    bit           em;
    bit           ee;
    logic [NR-1:0] el;
    int           ec;
  } vec_t;

  vec_t         tbl [18];
  logic [W-1:0] d;

  initial begin
    // Channel 1 walk: lock, isolated error, flywheel, loss after four errors, relock.
    tbl[0]  = '{1, 1, 24'h0,      1, 1, 0, 0, 3'b000, 0};
    tbl[1]  = '{1, 1, 24'h0,      1, 1, 1, 0, 3'b000, 0};
    tbl[2]  = '{1, 1, 24'h0,      1, 1, 1, 0, 3'b000, 0};
    tbl[3]  = '{1, 1, 24'h0,      1, 1, 1, 0, 3'b000, 0};
    tbl[4]  = '{1, 1, 24'h0,      1, 1, 1, 0, 3'b010, 0};
    tbl[5]  = '{0, 0, 24'h0,      0, 0, 0, 0, 3'b010, 0};
    tbl[6]  = '{1, 3, 24'h5A5A5A, 0, 0, 0, 0, 3'b010, 0};
    tbl[7]  = '{1, 1, 24'h1,      1, 1, 0, 1, 3'b010, 1};
    tbl[8]  = '{1, 1, 24'h0,      1, 1, 1, 0, 3'b010, 1};
    tbl[9]  = '{1, 1, 24'h1,      1, 1, 0, 1, 3'b010, 2};
    tbl[10] = '{1, 1, 24'h1,      1, 1, 0, 1, 3'b010, 3};
    tbl[11] = '{1, 1, 24'h1,      1, 1, 0, 1, 3'b010, 4};
    tbl[12] = '{1, 1, 24'h1,      1, 1, 0, 1, 3'b000, 5};
    tbl[13] = '{1, 1, 24'h0,      1, 1, 0, 0, 3'b000, 5};
    tbl[14] = '{1, 1, 24'h0,      1, 1, 1, 0, 3'b000, 5};
    tbl[15] = '{1, 1, 24'h0,      1, 1, 1, 0, 3'b000, 5};
    tbl[16] = '{1, 1, 24'h0,      1, 1, 1, 0, 3'b000, 5};
    tbl[17] = '{1, 1, 24'h0,      1, 1, 1, 0, 3'b010, 5};

    model_reset();
    send(0, 0, '0, 0, 0, 1);
    send(0, 0, '0, 0, 1, 1);

    for (int i = 0; i < 18; i++) begin
      d = tbl[i].adv ? (gen_word(tbl[i].ch) ^ tbl[i].xm) : tbl[i].xm;
      drive(tbl[i].v, tbl[i].ch, d, 0, 1, 0);
      check($sformatf("vec%0d_result", i), 32'({chk_out_valid, chk_match, chk_err}),
            32'({tbl[i].ev, tbl[i].em, tbl[i].ee}));
      if (tbl[i].ev) check($sformatf("vec%0d_ch", i), 32'(chk_out_ch), 32'(tbl[i].ch));
      check($sformatf("vec%0d_locked", i), 32'(chk_locked), 32'(tbl[i].el));
      check($sformatf("vec%0d_cnt", i), 32'(cnt_rd_val), 32'(tbl[i].ec));
    end

    // Reset while locked, with a word in flight.
    drive(1, 1, gen_word(1), 0, 1, 0);
    check("pre_rst_result", 32'({chk_out_valid, chk_match, chk_err}), 32'(3'b110));
    drive(1, 1, gen_word(1), 0, 1, 1);
    check("rst_result", 32'({chk_out_valid, chk_match, chk_err}), 32'(3'b000));
    check("rst_locked", 32'(chk_locked), 32'(0));
    check("rst_cnt", 32'(cnt_rd_val), 32'(0));
    model_reset();
    send(0, 0, '0, 0, 1, 0);

    // Saturation and clear interplay on channel 0.
    for (int i = 0; i < 5; i++) send(1, 0, gen_word(0), 0, 0, 0);
    check("lock_after_5", 32'(chk_locked[0]), 32'(1));
    for (int i = 0; i < 20; i++) begin
      send(1, 0, gen_word(0) ^ 24'h000001, 0, 0, 0);
      send(1, 0, gen_word(0), 0, 0, 0);
    end
    check("sat_cnt", 32'(cnt_rd_val), 32'(CMAX));
    send(1, 0, gen_word(0) ^ 24'h000001, 1, 0, 0);
    check("clr_with_inc", 32'(cnt_rd_val), 32'(1));
    send(0, 0, '0, 1, 0, 0);
    check("clr_alone", 32'(cnt_rd_val), 32'(0));

    // All-zero words never match.
    for (int i = 0; i < 8; i++) send(1, 2, '0, 0, 2, 0);
    check("zero_no_lock", 32'(chk_locked[2]), 32'(0));

    // Randomized interleaved traffic with corruption, zero words, gaps and clears.
    for (int n = 0; n < 1500; n++) begin
      int           ch;
      bit           v;
      if (n == 700) begin
        for (int g = 0; g < 50; g++) send(0, 0, '0, 0, $urandom_range(0, 3), 0);
      end
      v  = ($urandom_range(0, 3) != 0);
      ch = $urandom_range(0, 3);
      if (!v || ch == NR) begin
        d = W'($urandom);
      end else begin
        d = gen_word(ch);
        if ($urandom_range(0, 9) == 0) d = d ^ W'($urandom_range(1, 24'hFFFFFF));
        if ($urandom_range(0, 49) == 0) d = '0;
      end
      send(v, ch, d, ($urandom_range(0, 15) == 0), $urandom_range(0, 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
